// File: rtl/jenc_pkg.sv
// ============================================================================
//  jenc_pkg : shared constants and types for the jump_field_encoder slice
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package jenc_pkg;

   localparam int unsigned JENC_ADDR_W   = 32;
   localparam int unsigned JENC_IDX_W    = JENC_ADDR_W - 6;
   localparam int unsigned JENC_REGION_W = 4;

   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_REGION   = 2'b10;

   typedef struct packed {
      logic [JENC_ADDR_W-1:0] target;
      logic [JENC_ADDR_W-1:0] pc_plus4;
   } stage_payload_t;

endpackage

`default_nettype wire

// File: rtl/jenc_pipe_stage.sv
// ============================================================================
//  jenc_pipe_stage : generic valid/ready register slice, full throughput
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module jenc_pipe_stage #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   logic              valid_q;
   logic              valid_d;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;

   // Ready when empty or when the held entry leaves this same cycle.
   assign in_ready  = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (in_ready) begin
         valid_d = in_valid;
         if (in_valid) begin
            data_d = in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/jump_field_encoder.sv
// ============================================================================
//  jump_field_encoder : byte-address jump target -> 26-bit J/JAL instr_index
//  Optional macro JENC_ERR_COUNT_EN adds err_count / err_clr.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module jump_field_encoder
   import jenc_pkg::*;
#(
   parameter int ADDR_W   = JENC_ADDR_W,
   parameter int IDX_W    = JENC_IDX_W,
   parameter int REGION_W = JENC_REGION_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_target,
   input  logic [ADDR_W-1:0] in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_index,
   output logic [1:0]        out_err
`ifdef JENC_ERR_COUNT_EN
   ,
   input  logic              err_clr,
   output logic [15:0]       err_count
`endif
);

   localparam int S1_W = 2 * ADDR_W;
   localparam int S2_W = IDX_W + 2;

   logic [S1_W-1:0]   s1_in_data;
   logic              s1_valid;
   logic              s1_ready;
   logic [S1_W-1:0]   s1_data;
   logic [ADDR_W-1:0] s1_target;
   logic [ADDR_W-1:0] s1_pc_plus4;

   logic [IDX_W-1:0]  enc_index;
   logic [1:0]        enc_err;
   logic [S2_W-1:0]   s2_in_data;
   logic [S2_W-1:0]   s2_data;

   // Carry out of the PC increment is dropped: the region wraps to zero.
   assign s1_in_data = {in_target, in_pc + ADDR_W'(4)};

   jenc_pipe_stage #(
      .DATA_W (S1_W)
   ) u_stage1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (s1_in_data),
      .out_valid (s1_valid),
      .out_ready (s1_ready),
      .out_data  (s1_data)
   );

   assign s1_target   = s1_data[S1_W-1:ADDR_W];
   assign s1_pc_plus4 = s1_data[ADDR_W-1:0];

   always_comb begin
      enc_index = s1_target[IDX_W+1:2];
      enc_err   = 2'b00;
      if (|s1_target[1:0]) begin
         enc_err = enc_err | ERR_MISALIGN;
      end
      if (s1_target[ADDR_W-1 -: REGION_W] != s1_pc_plus4[ADDR_W-1 -: REGION_W]) begin
         enc_err = enc_err | ERR_REGION;
      end
   end

   // Only the region bits of pc_plus4 take part in the encode.
   logic unused_pc_bits;
   assign unused_pc_bits = ^s1_pc_plus4[ADDR_W-REGION_W-1:0];

   assign s2_in_data = {enc_index, enc_err};

   jenc_pipe_stage #(
      .DATA_W (S2_W)
   ) u_stage2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s1_valid),
      .in_ready  (s1_ready),
      .in_data   (s2_in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s2_data)
   );

   assign out_index = s2_data[S2_W-1:2];
   assign out_err   = s2_data[1:0];

`ifdef JENC_ERR_COUNT_EN
   logic [15:0] err_count_q;
   logic [15:0] err_count_d;

   always_comb begin
      err_count_d = err_count_q;
      if (err_clr) begin
         err_count_d = 16'h0000;
      end else if (out_valid && out_ready && (|out_err) && (err_count_q != 16'hFFFF)) begin
         err_count_d = err_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_count_q <= 16'h0000;
      end else begin
         err_count_q <= err_count_d;
      end
   end

   assign err_count = err_count_q;
`endif

endmodule

`default_nettype wire
